// File: rtl/seven_seg_scanner.sv
// Multiplexed hex seven-segment scanner with dead time, decimal points,
// leading-zero blanking, per-digit blink and frame-synchronous value updates.
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned DEAD_CYCLES  = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_en,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned PW = $clog2(DIGIT_CYCLES);
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PLast = PW'(DIGIT_CYCLES - 1);
  localparam logic [DW-1:0] DLast = DW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLast = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]           p_q, p_d;
  logic [DW-1:0]           d_q, d_d;
  logic [BW-1:0]           fc_q, fc_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d, sh_value_q, sh_value_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d, sh_blink_q, sh_blink_d;
  logic                    pend_lz_q, pend_lz_d, sh_lz_q, sh_lz_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic                    frame_end;
  logic                    zeros_above;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    frame_end = (p_q == PLast) && (d_q == DLast);

    p_d = (p_q == PLast) ? '0 : p_q + 1'b1;
    d_d = d_q;
    if (p_q == PLast) begin
      d_d = (d_q == DLast) ? '0 : d_q + 1'b1;
    end

    fc_d    = fc_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (fc_q == BLast) begin
        fc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end

    // Shadow takes the old pending contents before a same-cycle load overwrites pending.
    sh_value_d = sh_value_q;
    sh_dp_d    = sh_dp_q;
    sh_blink_d = sh_blink_q;
    sh_lz_d    = sh_lz_q;
    if (frame_end && pend_flag_q) begin
      sh_value_d = pend_value_q;
      sh_dp_d    = pend_dp_q;
      sh_blink_d = pend_blink_q;
      sh_lz_d    = pend_lz_q;
    end

    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_blink_d = pend_blink_q;
    pend_lz_d    = pend_lz_q;
    pend_flag_d  = pend_flag_q;
    if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp;
      pend_blink_d = blink;
      pend_lz_d    = lz_en;
      pend_flag_d  = 1'b1;
    end else if (frame_end) begin
      pend_flag_d = 1'b0;
    end

    zeros_above = 1'b1;
    lz_blank    = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      zeros_above = zeros_above & (sh_value_q[4*k +: 4] == 4'h0);
      lz_blank[k] = zeros_above;
    end

    nib   = sh_value_q[4*int'(d_q) +: 4];
    blank = (32'(p_q) < DEAD_CYCLES) || (sh_lz_q && lz_blank[d_q]) ||
            (phase_q && sh_blink_q[d_q]);

    seg_d = 8'hFF;
    an_d  = '1;
    if (!blank) begin
      seg_d = {~sh_dp_q[d_q], hex7(nib)};
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        an_d[k] = (k != int'(d_q));
      end
    end

    tick_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      p_q          <= '0;
      d_q          <= '0;
      fc_q         <= '0;
      phase_q      <= 1'b0;
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      pend_lz_q    <= 1'b0;
      pend_flag_q  <= 1'b0;
      sh_value_q   <= '0;
      sh_dp_q      <= '0;
      sh_blink_q   <= '0;
      sh_lz_q      <= 1'b0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
      tick_q       <= 1'b0;
    end else begin
      p_q          <= p_d;
      d_q          <= d_d;
      fc_q         <= fc_d;
      phase_q      <= phase_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_blink_q <= pend_blink_d;
      pend_lz_q    <= pend_lz_d;
      pend_flag_q  <= pend_flag_d;
      sh_value_q   <= sh_value_d;
      sh_dp_q      <= sh_dp_d;
      sh_blink_q   <= sh_blink_d;
      sh_lz_q      <= sh_lz_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: a time-indexed reference model pushes the expected seg/an/frame_tick
// for every edge; the value observed after that edge is popped and compared.
module tb_seven_seg_scanner;

  localparam int ND    = 4;
  localparam int DC    = 4;
  localparam int DEAD  = 1;
  localparam int BF    = 2;
  localparam int FRAME = ND * DC;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp = '0;
  logic          load = 1'b0;
  logic [3:0]    blink = '0;
  logic          lz_en = 1'b0;
  logic [7:0]    seg;
  logic [3:0]    an;
  logic          frame_tick;

  int total = 0;
  int bad   = 0;

  // Model state: m_t counts cycles since reset release.
  int unsigned m_t = 0;
  logic [15:0] m_pv = '0, m_sv = '0;
  logic [3:0]  m_pdp = '0, m_sdp = '0, m_pbl = '0, m_sbl = '0;
  logic        m_plz = 1'b0, m_slz = 1'b0, m_flag = 1'b0;

  logic [12:0] sb_q[$];

  seven_seg_scanner #(
    .NUM_DIGITS  (ND),
    .DIGIT_CYCLES(DC),
    .DEAD_CYCLES (DEAD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .dp        (dp),
    .load      (load),
    .blink     (blink),
    .lz_en     (lz_en),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] hex_ref(input logic [3:0] n);
    logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[n];
  endfunction

  function automatic logic [12:0] model_out();
    int   p  = int'(m_t % DC);
    int   d  = int'((m_t / DC) % ND);
    logic fe = (m_t % FRAME) == FRAME - 1;
    logic ph = ((m_t / FRAME) / BF) % 2 == 1;
    logic blank;
    logic [7:0] s;
    logic [3:0] a;
    blank = (p < DEAD) || (ph && m_sbl[d]) || (m_slz && d > 0 && (m_sv >> (4 * d)) == 16'h0);
    if (blank) begin
      s = 8'hFF;
      a = 4'hF;
    end else begin
      s = hex_ref(m_sv[4*d +: 4]) & (m_sdp[d] ? 8'h7F : 8'hFF);
      a = ~(4'b0001 << d);
    end
    return {fe, a, s};
  endfunction

  task automatic step();
    logic [12:0] e;
    logic        fe;
    if (!reset) begin
      sb_q.push_back({1'b0, 4'hF, 8'hFF});
      m_t = 0;
      {m_pv, m_sv, m_pdp, m_sdp, m_pbl, m_sbl, m_plz, m_slz, m_flag} = '0;
    end else begin
      sb_q.push_back(model_out());
      fe = (m_t % FRAME) == FRAME - 1;
      if (fe && m_flag) begin
        m_sv = m_pv; m_sdp = m_pdp; m_sbl = m_pbl; m_slz = m_plz;
      end
      if (load) begin
        m_pv = value; m_pdp = dp; m_pbl = blink; m_plz = lz_en; m_flag = 1'b1;
      end else if (fe) begin
        m_flag = 1'b0;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("seg", 32'(seg), 32'(e[7:0]));
    check_eq("an", 32'(an), 32'(e[11:8]));
    check_eq("frame_tick", 32'(frame_tick), 32'(e[12]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                         input logic lz);
    value = v; dp = d; blink = b; lz_en = lz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    // Reset and plain scan of an all-zero shadow.
    reset = 1'b0;
    run(3);
    reset = 1'b1;
    run(2 * FRAME + 8);

    // Mid-frame load: old digits hold until the frame boundary.
    while (m_t % FRAME != 6) step();
    do_load(16'h12AF, 4'b0100, 4'b0000, 1'b0);
    run(2 * FRAME + 4);

    // Leading-zero blanking, then all-zero value.
    do_load(16'h0030, 4'b0000, 4'b0000, 1'b1);
    run(2 * FRAME + 4);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    run(2 * FRAME + 4);

    // Blink on digit 0 across several blink half-periods.
    do_load(16'h12AF, 4'b0000, 4'b0001, 1'b0);
    run(6 * FRAME);

    // Load exactly on the frame-end cycle.
    do_load(16'h4321, 4'b0000, 4'b0000, 1'b0);
    while (m_t % FRAME != FRAME - 1) step();
    do_load(16'h5555, 4'b0000, 4'b0000, 1'b0);
    run(3 * FRAME);

    // Reset mid-scan with pending data outstanding.
    while (m_t % FRAME != 5) step();
    do_load(16'h9999, 4'b1111, 4'b0000, 1'b0);
    while (m_t % FRAME != 10) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    run(3 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
